// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for a 16:1 select tree with lock-style ownership.
// Optional hold timeout: define RR_ARBITER_16_TIMEOUT_EN to enable it.
module rr_arbiter_16 #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req,
   output logic [15:0] gnt,
   output logic        gnt_valid,
   output logic        sel3,
   output logic        sel2,
   output logic        sel1,
   output logic        sel0
);

   typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

   state_t      state, state_nxt;
   logic [15:0] gnt_nxt;
   logic        valid_nxt;
   logic [3:0]  sel_q, sel_nxt;
   logic [3:0]  last_q, last_nxt;

   logic [3:0]  start;
   logic [15:0] cand;
   logic        found;
   logic [3:0]  win;
   logic [3:0]  idx;
   logic        rearb;
   logic        take;
   logic        preempt;

`ifdef RR_ARBITER_16_TIMEOUT_EN
   logic [7:0] hold_cnt;

   // Count reaching MAX_HOLD-1 means the owner has already held MAX_HOLD cycles.
   assign preempt = (state == OWNED) && (hold_cnt >= 8'(MAX_HOLD - 1)) && (|(req & ~gnt));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt <= 8'h00;
      end else if (take) begin
         hold_cnt <= 8'h00;
      end else if ((state == OWNED) && (hold_cnt != 8'hFF)) begin
         hold_cnt <= hold_cnt + 8'h01;
      end
   end
`else
   assign preempt = 1'b0;
`endif

   // Search from one past the owner (or pointer) with the owner masked out.
   assign start = (state == OWNED) ? (sel_q + 4'd1) : (last_q + 4'd1);
   assign cand  = (state == OWNED) ? (req & ~gnt) : req;
   assign rearb = (state == OWNED) ? (!req[sel_q] || preempt) : 1'b1;
   assign take  = rearb && found;

   always_comb begin
      found = 1'b0;
      win   = start;
      idx   = 4'h0;
      for (int i = 0; i < 16; i++) begin
         idx = start + 4'(i);
         if (!found && cand[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      valid_nxt = gnt_valid;
      sel_nxt   = sel_q;
      last_nxt  = last_q;
      if (rearb) begin
         if (found) begin
            state_nxt = OWNED;
            gnt_nxt   = 16'h0001 << win;
            valid_nxt = 1'b1;
            sel_nxt   = win;
            last_nxt  = win;
         end else begin
            // sel is left alone so the select tree does not move while idle.
            state_nxt = IDLE;
            gnt_nxt   = 16'h0000;
            valid_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         gnt       <= 16'h0000;
         gnt_valid <= 1'b0;
         sel_q     <= 4'h0;
         last_q    <= 4'hF;
      end else begin
         state     <= state_nxt;
         gnt       <= gnt_nxt;
         gnt_valid <= valid_nxt;
         sel_q     <= sel_nxt;
         last_q    <= last_nxt;
      end
   end

   assign {sel3, sel2, sel1, sel0} = sel_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Randomized and directed bench for rr_arbiter_16 against an ownership-level model.
module tb_rr_arbiter_16;

   localparam int unsigned MAX_HOLD = 8;

   logic        clk;
   logic        rst_n;
   logic [15:0] req;
   logic [15:0] gnt;
   logic        gnt_valid;
   logic        sel3, sel2, sel1, sel0;

   int compared;
   int mismatched;

   // Model: who owns the mux, the round-robin pointer, and how long the owner has held.
   int          m_owner;
   int          m_last;
   int          m_sel;
   int          m_hold;
   logic [15:0] exp_gnt;
   logic        exp_valid;
   logic [3:0]  exp_sel;

   rr_arbiter_16 #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .sel3      (sel3),
      .sel2      (sel2),
      .sel1      (sel1),
      .sel0      (sel0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int first_from(input logic [15:0] v, input int from);
      for (int i = 0; i < 16; i++) begin
         if (v[(from + i) % 16]) return (from + i) % 16;
      end
      return -1;
   endfunction

   task automatic model_expect();
      exp_valid = (m_owner >= 0);
      exp_gnt   = (m_owner >= 0) ? (16'h0001 << m_owner) : 16'h0000;
      exp_sel   = 4'(m_sel);
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = 15;
      m_sel   = 0;
      m_hold  = 0;
      model_expect();
   endtask

   task automatic model_grant(input int w);
      m_owner = w;
      m_last  = w;
      m_sel   = w;
      m_hold  = 0;
   endtask

   task automatic model_step(input logic [15:0] r);
      int          w;
      logic [15:0] others;
      bit          give_up;
      if (m_owner < 0) begin
         w = first_from(r, m_last + 1);
         if (w >= 0) model_grant(w);
      end else begin
         others = r;
         others[m_owner] = 1'b0;
         give_up = !r[m_owner];
`ifdef RR_ARBITER_16_TIMEOUT_EN
         if ((m_hold + 1 >= int'(MAX_HOLD)) && (others != 16'h0000)) give_up = 1'b1;
`endif
         if (give_up) begin
            w = first_from(others, m_owner + 1);
            if (w >= 0) model_grant(w);
            else m_owner = -1;
         end else if (m_hold < 255) begin
            m_hold++;
         end
      end
      model_expect();
   endtask

   // Drives one request vector for one clock, advances the model, lands #1 after the edge.
   task automatic cycle(input logic [15:0] r);
      req = r;
      @(posedge clk);
      model_step(r);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 16'h0000;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      compared++;
      if ({gnt_valid, gnt, sel3, sel2, sel1, sel0} !== {1'b0, 16'h0000, 4'h0}) begin
         mismatched++;
         $display("FAIL reset: got v=%0b gnt=%h sel=%h, want v=0 gnt=0000 sel=0",
                  gnt_valid, gnt, {sel3, sel2, sel1, sel0});
      end
   endtask

   task automatic test_single();
      do_reset();
      cycle(16'h0001);
      compared++;
      if ({gnt_valid, gnt, sel3, sel2, sel1, sel0} !== {1'b1, 16'h0001, 4'h0}) begin
         mismatched++;
         $display("FAIL single_grant: got v=%0b gnt=%h sel=%h, want v=1 gnt=0001 sel=0",
                  gnt_valid, gnt, {sel3, sel2, sel1, sel0});
      end
      cycle(16'h0000);
      compared++;
      if ({gnt_valid, gnt, sel3, sel2, sel1, sel0} !== {1'b0, 16'h0000, 4'h0}) begin
         mismatched++;
         $display("FAIL single_release: got v=%0b gnt=%h sel=%h, want v=0 gnt=0000 sel=0",
                  gnt_valid, gnt, {sel3, sel2, sel1, sel0});
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] want;
      do_reset();
      cycle(16'hFFFF);
      for (int n = 0; n <= 16; n++) begin
         want = 16'h0001 << (n % 16);
         compared++;
         if ({gnt_valid, gnt, sel3, sel2, sel1, sel0} !== {1'b1, want, 4'(n % 16)} ||
             {gnt_valid, gnt, sel3, sel2, sel1, sel0} !== {exp_valid, exp_gnt, exp_sel}) begin
            mismatched++;
            $display("FAIL sweep[%0d]: got v=%0b gnt=%h sel=%h, want v=1 gnt=%h sel=%h",
                     n, gnt_valid, gnt, {sel3, sel2, sel1, sel0}, want, 4'(n % 16));
         end
         if (n < 16) cycle(~want);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      cycle(16'h0020);
      cycle(16'h0021);
      compared++;
      if ({gnt_valid, gnt, sel3, sel2, sel1, sel0} !== {1'b1, 16'h0020, 4'h5}) begin
         mismatched++;
         $display("FAIL wrap_hold: got v=%0b gnt=%h sel=%h, want v=1 gnt=0020 sel=5",
                  gnt_valid, gnt, {sel3, sel2, sel1, sel0});
      end
      cycle(16'h0001);
      compared++;
      if ({gnt_valid, gnt, sel3, sel2, sel1, sel0} !== {1'b1, 16'h0001, 4'h0}) begin
         mismatched++;
         $display("FAIL wrap_next: got v=%0b gnt=%h sel=%h, want v=1 gnt=0001 sel=0",
                  gnt_valid, gnt, {sel3, sel2, sel1, sel0});
      end
   endtask

   task automatic test_owner15_reset();
      do_reset();
      cycle(16'h8000);
      cycle(16'h8004);
      cycle(16'h0004);
      compared++;
      if ({gnt_valid, gnt, sel3, sel2, sel1, sel0} !== {1'b1, 16'h0004, 4'h2}) begin
         mismatched++;
         $display("FAIL wrap15: got v=%0b gnt=%h sel=%h, want v=1 gnt=0004 sel=2",
                  gnt_valid, gnt, {sel3, sel2, sel1, sel0});
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      compared++;
      if ({gnt_valid, gnt, sel3, sel2, sel1, sel0} !== {1'b0, 16'h0000, 4'h0}) begin
         mismatched++;
         $display("FAIL async_reset: got v=%0b gnt=%h sel=%h, want v=0 gnt=0000 sel=0",
                  gnt_valid, gnt, {sel3, sel2, sel1, sel0});
      end
      @(negedge clk);
      rst_n = 1'b1;
      cycle(16'h8001);
      compared++;
      if ({gnt_valid, gnt, sel3, sel2, sel1, sel0} !== {1'b1, 16'h0001, 4'h0}) begin
         mismatched++;
         $display("FAIL post_reset_ptr: got v=%0b gnt=%h sel=%h, want v=1 gnt=0001 sel=0",
                  gnt_valid, gnt, {sel3, sel2, sel1, sel0});
      end
   endtask

   task automatic test_hold();
      logic [15:0] want;
      do_reset();
      for (int n = 0; n < 4 * int'(MAX_HOLD); n++) begin
         cycle(16'h0088);
`ifdef RR_ARBITER_16_TIMEOUT_EN
         want = ((n / int'(MAX_HOLD)) % 2 == 0) ? 16'h0008 : 16'h0080;
`else
         want = 16'h0008;
`endif
         compared++;
         if (gnt !== want || {gnt_valid, gnt, sel3, sel2, sel1, sel0} !== {exp_valid, exp_gnt, exp_sel}) begin
            mismatched++;
            $display("FAIL hold_pair[%0d]: got gnt=%h sel=%h, want gnt=%h sel=%h",
                     n, gnt, {sel3, sel2, sel1, sel0}, want, exp_sel);
         end
      end
      do_reset();
      for (int n = 0; n < 3 * int'(MAX_HOLD); n++) begin
         cycle(16'h0008);
         compared++;
         if ({gnt_valid, gnt, sel3, sel2, sel1, sel0} !== {1'b1, 16'h0008, 4'h3}) begin
            mismatched++;
            $display("FAIL hold_alone[%0d]: got v=%0b gnt=%h sel=%h, want v=1 gnt=0008 sel=3",
                     n, gnt_valid, gnt, {sel3, sel2, sel1, sel0});
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] r;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 7))
            0:       r = 16'h0000;
            1:       r = 16'h0001 << $urandom_range(0, 15);
            default: r = 16'($urandom) & 16'($urandom);
         endcase
         if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
         cycle(r);
         compared++;
         if ({gnt_valid, gnt, sel3, sel2, sel1, sel0} !== {exp_valid, exp_gnt, exp_sel} ||
             !$onehot0(gnt) || gnt_valid !== (|gnt)) begin
            mismatched++;
            $display("FAIL random[%0d] req=%h: got v=%0b gnt=%h sel=%h, want v=%0b gnt=%h sel=%h",
                     n, r, gnt_valid, gnt, {sel3, sel2, sel1, sel0}, exp_valid, exp_gnt, exp_sel);
         end
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      rst_n      = 1'b0;
      req        = 16'h0000;
      model_reset();
      test_reset();
      test_single();
      test_back_to_back();
      test_wrap();
      test_owner15_reset();
      test_hold();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/rr_arbiter_16.md
Name: rr_arbiter_16

Overview:
- Round-robin arbiter that shares one 16:1 one-bit selection datapath between 16 requesters.
- Drives the four mux select lines (sel3..sel0) plus a one-hot grant vector.
- Sits between requesting units (register-file readers, I/O sources) and the 16-input select tree.
- Grants are held until the owner releases its request, giving a lock-style ownership handshake.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles per owner when the timeout feature is compiled in; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  16  request vector; bit k asserted = requester k wants the mux
- gnt  output  16  one-hot grant vector, registered
- gnt_valid  output  1  high while any grant is active
- sel3  output  1  mux select bit 3 (MSB of owner index)
- sel2  output  1  mux select bit 2
- sel1  output  1  mux select bit 1
- sel0  output  1  mux select bit 0 (LSB)

Behaviour:
- All outputs are registered; no combinational path from req to any output.
- Asynchronous reset (rst_n low):
  - state=IDLE, gnt=16'h0000, gnt_valid=0, {sel3..sel0}=4'h0.
  - Round-robin pointer last=15, so the first search starts at index 0.
- States: IDLE (no owner) and OWNED (one owner).
- IDLE:
  - If req != 0, pick the first set bit searching upward from last+1 (mod 16).
  - At the next edge: gnt = one-hot of winner, gnt_valid=1, sel = winner index, last = winner, state=OWNED.
  - Latency is 1 cycle from req sampled to grant visible.
- OWNED:
  - Hold the grant while req[owner] is sampled high.
  - When req[owner] is sampled low, re-arbitrate in the same cycle over req with the owner bit masked, starting at owner+1 (mod 16).
    - Another request found: new grant at the next edge, no idle gap; last updated.
    - None found: next edge gives gnt=0, gnt_valid=0, state=IDLE.
- sel3..sel0 keep their last value when no grant is active, so the mux output does not glitch; they change only on a new grant.
- Wrap-around: the search order after owner 15 is 0, 1, 2, ...
- A requester that drops and re-raises req while others wait is served only after every waiting index between it and itself in round-robin order.
- Request bits for non-owners may toggle freely; only the value sampled at an arbitration edge matters.
- Reset asserted mid-grant: outputs clear immediately (asynchronously); after release the pointer restarts at index 0.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_valid == |gnt.
  - sel equals the index of the set gnt bit whenever gnt_valid=1.

Optional Feature:
- Macro RR_ARBITER_16_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on each new grant and increments every OWNED cycle.
  - When the count reaches MAX_HOLD and any other req bit is set, the owner is pre-empted: the next grant goes to the next requester in round-robin order at the following edge, even if req[owner] is still high.
  - If no other requester is waiting, the owner keeps the grant and the counter saturates.
- Undefined: no counter exists; ownership is held indefinitely while req[owner] stays high.

Test Plan:
- Reset then req=16'h0001 → one cycle later gnt=16'h0001, gnt_valid=1, sel=4'h0; drop req → next cycle gnt=0, gnt_valid=0, sel stays 4'h0.
- req=16'hFFFF with the owner released after each grant → grants step 0,1,2,...,15,0 with no idle cycle between owners; sel tracks the index.
- Owner 5, req=16'h0021 (bits 0 and 5); drop bit 5 → next grant goes to bit 0 (wrap past 15), sel=4'h0.
- Owner 15, pointer wrap: req=16'h8004, release 15 → gnt=16'h0004, sel=4'h2; assert rst_n=0 mid-grant → outputs clear the same cycle; after release, req=16'h8001 → grant goes to bit 0.
- With RR_ARBITER_16_TIMEOUT_EN and MAX_HOLD=8: bits 3 and 7 held high continuously → grant alternates 3 then 7, 8 cycles each; with only bit 3 high, the grant is never dropped.
